// File: rtl/axi_lite_ram_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite RAM slave.
package axi_lite_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } rstate_t;

    function automatic logic [1:0] resp_for(input logic ok);
        return ok ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; modport s is the slave view, m the master view.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_sdp_ram.sv
// Simple dual-port RAM: byte-enabled synchronous write, synchronous read-first read.
module sdp_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB   = DW / 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [NB-1:0] wbe,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Both ports use non-blocking updates, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave backed by a word RAM; independent read and write FSMs.
// Define AXI_LITE_RAM_WSTRB_EN to honour wstrb; otherwise writes update the full word.
module axi_lite_ram
    import axi_lite_ram_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input logic    aclk,
    input logic    areset,
    axi4_lite_if.s axi
);

    localparam int          NB    = DW / 8;
    localparam int          OFF   = $clog2(NB);
    localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);

    function automatic logic in_range(input logic [AW-1:0] a);
        return 64'(a) < LIMIT;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
        return a[OFF +: IW];
    endfunction

    wstate_t       wstate;
    wstate_t       wstate_nx;
    logic          awready_int;
    logic          wready_int;
    logic          commit;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [NB-1:0] c_strb;
    logic [AW-1:0] awaddr_q;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wstrb_q;
    logic [1:0]    bresp_q;
    logic          ram_we;
    logic [NB-1:0] ram_wbe;

    rstate_t       rstate;
    rstate_t       rstate_nx;
    logic          arready_int;
    logic [AW-1:0] araddr_q;
    logic [1:0]    rresp_q;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;

    // Write FSM: the commit address/data come live from the bus or from whichever half was latched.
    always_comb begin
        wstate_nx   = wstate;
        awready_int = 1'b0;
        wready_int  = 1'b0;
        commit      = 1'b0;
        c_addr      = axi.awaddr;
        c_data      = axi.wdata;
        c_strb      = axi.wstrb;
        case (wstate)
            W_IDLE: begin
                awready_int = 1'b1;
                wready_int  = 1'b1;
                if (axi.awvalid && axi.wvalid) begin
                    commit    = 1'b1;
                    wstate_nx = W_RESP;
                end else if (axi.awvalid) begin
                    wstate_nx = W_WAIT_W;
                end else if (axi.wvalid) begin
                    wstate_nx = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                wready_int = 1'b1;
                c_addr     = awaddr_q;
                if (axi.wvalid) begin
                    commit    = 1'b1;
                    wstate_nx = W_RESP;
                end
            end
            W_WAIT_AW: begin
                awready_int = 1'b1;
                c_data      = wdata_q;
                c_strb      = wstrb_q;
                if (axi.awvalid) begin
                    commit    = 1'b1;
                    wstate_nx = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    wstate_nx = W_IDLE;
                end
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_nx;
        end
    end

    always_ff @(posedge aclk) begin
        if (wstate == W_IDLE && axi.awvalid) begin
            awaddr_q <= axi.awaddr;
        end
        if (wstate == W_IDLE && axi.wvalid) begin
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
        end
        if (commit) begin
            bresp_q <= resp_for(in_range(c_addr));
        end
    end

    assign ram_we = commit && !areset && in_range(c_addr);

`ifdef AXI_LITE_RAM_WSTRB_EN
    assign ram_wbe = c_strb;
`else
    logic unused_strb;
    assign ram_wbe     = '1;
    assign unused_strb = ^c_strb;
`endif

    // Read FSM: AR accepted at edge N, RAM read at N+1, response presented from then on.
    always_comb begin
        rstate_nx   = rstate;
        arready_int = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready_int = 1'b1;
                if (axi.arvalid) begin
                    rstate_nx = R_READ;
                end
            end
            R_READ: rstate_nx = R_RESP;
            R_RESP: begin
                if (axi.rready) begin
                    rstate_nx = R_IDLE;
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_nx;
        end
    end

    always_ff @(posedge aclk) begin
        if (rstate == R_IDLE && axi.arvalid) begin
            araddr_q <= axi.araddr;
            rresp_q  <= resp_for(in_range(axi.araddr));
        end
    end

    assign ram_re = (rstate == R_READ) && !areset;

    sdp_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (word_idx(c_addr)),
        .wdata (c_data),
        .wbe   (ram_wbe),
        .re    (ram_re),
        .raddr (word_idx(araddr_q)),
        .rdata (ram_rdata)
    );

    // Every output is forced quiet while reset is held, independent of FSM state.
    assign axi.awready = awready_int && !areset;
    assign axi.wready  = wready_int && !areset;
    assign axi.arready = arready_int && !areset;
    assign axi.bvalid  = (wstate == W_RESP) && !areset;
    assign axi.rvalid  = (rstate == R_RESP) && !areset;
    assign axi.bresp   = axi.bvalid ? bresp_q : RESP_OKAY;
    assign axi.rresp   = axi.rvalid ? rresp_q : RESP_OKAY;
    assign axi.rdata   = (axi.rvalid && rresp_q == RESP_OKAY) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: latency, split AW/W, strobes, range errors, backpressure, reset.
module tb_axi_lite_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi4_lite_if #(.AW(32), .DW(32)) bus ();

    axi_lite_ram #(.AW(32), .DW(32), .DEPTH(1024)) dut (
        .aclk   (clk),
        .areset (rst),
        .axi    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input int stall, input string tag);
        int n;
        @(negedge clk);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; bus.bready = 1'b0;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_awwrdy"}, 64'(bus.awready && bus.wready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk({tag, "_bvalid"}, 64'(bus.bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(bus.bresp), 64'(exp_resp));
        for (int i = 0; i < stall; i++) begin
            bus.awaddr = addr + 32'd4; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_rdy"}, 64'(bus.awready || bus.wready), 64'd0);
            chk({tag, "_stall_bvalid"}, 64'(bus.bvalid), 64'd1);
            chk({tag, "_stall_bresp"}, 64'(bus.bresp), 64'(exp_resp));
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk({tag, "_bdone"}, 64'(bus.bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int stall, input string tag);
        int n;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        n = 0;
        while (!bus.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrdy"}, 64'(bus.arready), 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        chk({tag, "_lat1"}, 64'(bus.rvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(exp_data));
        chk({tag, "_rresp"}, 64'(bus.rresp), 64'(exp_resp));
        for (int i = 0; i < stall; i++) begin
            bus.araddr = addr + 32'd4; bus.arvalid = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_arrdy"}, 64'(bus.arready), 64'd0);
            chk({tag, "_stall_rvalid"}, 64'(bus.rvalid), 64'd1);
            chk({tag, "_stall_rdata"}, 64'(bus.rdata), 64'(exp_data));
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0; bus.arvalid = 1'b0;
        chk({tag, "_rdone"}, 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] strb_exp;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
        chk("rst_valid", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        chk("rst_resp", 64'({bus.bresp, bus.rresp}), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);

        // Basic write then read.
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, "w10");
        axi_read(32'h10, 32'hDEADBEEF, 2'b00, 0, "r10");

        // AW three cycles ahead of W.
        @(negedge clk);
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("aw1st_rdy", 64'({bus.awready, bus.wready}), 64'b01);
        chk("aw1st_b0", 64'(bus.bvalid), 64'd0);
        repeat (2) @(negedge clk);
        chk("aw1st_b2", 64'(bus.bvalid), 64'd0);
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        chk("aw1st_bvalid", 64'(bus.bvalid), 64'd1);
        chk("aw1st_bresp", 64'(bus.bresp), 64'd0);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;

        // W ahead of AW.
        bus.wdata = 32'h9ABCDEF0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        chk("w1st_rdy", 64'({bus.awready, bus.wready}), 64'b10);
        chk("w1st_b0", 64'(bus.bvalid), 64'd0);
        @(negedge clk);
        chk("w1st_b1", 64'(bus.bvalid), 64'd0);
        bus.awaddr = 32'h24; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("w1st_bvalid", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        axi_read(32'h20, 32'h12345678, 2'b00, 0, "r20");
        axi_read(32'h24, 32'h9ABCDEF0, 2'b00, 0, "r24");

        // Byte strobes.
        axi_write(32'h30, 32'hFFFFFFFF, 4'hF, 2'b00, 0, "w30a");
        axi_write(32'h30, 32'h00000000, 4'b0101, 2'b00, 0, "w30b");
`ifdef AXI_LITE_RAM_WSTRB_EN
        strb_exp = 32'hFF00FF00;
`else
        strb_exp = 32'h00000000;
`endif
        axi_read(32'h30, strb_exp, 2'b00, 0, "r30");

        // Out of range, aliasing word 0 by index.
        axi_write(32'h0, 32'h0BADF00D, 4'hF, 2'b00, 0, "w0");
        axi_write(32'h1000, 32'hAAAA5555, 4'hF, 2'b10, 0, "woor");
        axi_read(32'h1000, 32'h0, 2'b10, 0, "roor");
        axi_read(32'h0, 32'h0BADF00D, 2'b00, 0, "r0");

        // Backpressure on B and R.
        axi_write(32'h50, 32'hCAFEF00D, 4'hF, 2'b00, 5, "wstall");
        axi_read(32'h50, 32'hCAFEF00D, 2'b00, 5, "rstall");

        // Same-edge read/write of 0x40, then reset while B is pending.
        axi_write(32'h40, 32'h1, 4'hF, 2'b00, 0, "w40a");
        @(negedge clk);
        bus.araddr = 32'h40; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.awaddr = 32'h40; bus.awvalid = 1'b1; bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("rf_rvalid", 64'(bus.rvalid), 64'd1);
        chk("rf_rdata", 64'(bus.rdata), 64'd1);
        chk("rf_bvalid", 64'(bus.bvalid), 64'd1);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("mid_rst_rdy", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);
        chk("post_rst_valid", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        axi_read(32'h40, 32'h2, 2'b00, 0, "r40");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 SHALL have parameter AW, default 32, meaning AXI address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DW-bit words.
REQ-004 SHALL have port aclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port axi, axi4_lite_if.s modport (AW/DW): slave side of the axi_interconnect output.

Function
REQ-007 SHALL decode the word index as addr[log2(DW/8)+:log2(DEPTH)]; low byte-offset bits ignored.
REQ-008 SHALL treat addr >= DEPTH*(DW/8) as out-of-range: respond SLVERR (2'b10), suppress the write, and return rdata 0.
REQ-009 Write FSM SHALL have states W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
REQ-010 W_IDLE: awready=1, wready=1; AW+W same edge -> W_RESP; AW only -> W_WAIT_W (latch awaddr); W only -> W_WAIT_AW (latch wdata/wstrb).
REQ-011 W_WAIT_W: awready=0, wready=1, exit to W_RESP on W handshake. W_WAIT_AW: wready=0, awready=1, exit to W_RESP on AW handshake.
REQ-012 SHALL commit the RAM write on the edge that completes the AW/W pair; bvalid=1 from the next cycle with bresp OKAY or SLVERR.
REQ-013 W_RESP: awready=wready=0; bvalid held with stable bresp until bready; on handshake -> W_IDLE, so at most one outstanding write.
REQ-014 Read FSM SHALL have states R_IDLE, R_READ, R_RESP.
REQ-015 R_IDLE: arready=1; AR handshake at edge N -> R_READ. R_READ: arready=0; RAM read at edge N+1 -> R_RESP.
REQ-016 R_RESP: rvalid=1; rdata/rresp stable until rready; on handshake -> R_IDLE, giving AR->R latency of 2 cycles.
REQ-017 Read and write FSMs SHALL operate independently and concurrently.
REQ-018 A read and a write to the same word on the same edge SHALL return the old data (read-first).
REQ-019 bresp/rresp SHALL be driven 2'b00 whenever the matching valid is low.

Reset
REQ-020 While areset=1 at a rising edge, both FSMs SHALL return to idle states.
REQ-021 Under reset, outputs SHALL be awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-022 Idle readies SHALL assert from the first cycle after reset deasserts.
REQ-023 Reset mid-transaction SHALL drop the pending response; a write already committed stays in RAM.
REQ-024 RAM contents SHALL NOT be reset.

Configuration
REQ-025 With AXI_LITE_RAM_WSTRB_EN defined, only bytes with wstrb[i]=1 SHALL be written.
REQ-026 Without AXI_LITE_RAM_WSTRB_EN, every accepted write SHALL update the full word regardless of wstrb.

Structure
REQ-027 Package axi_lite_ram_pkg SHALL hold resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the write- and read-state enums.
REQ-028 Sub-module sdp_ram SHALL be a simple dual-port RAM: one sync write port with byte enables and one sync read-first read port, parameterised DW/DEPTH.

Verification
REQ-029 Write 0x0000_0010 <- 0xDEADBEEF (AW+W same cycle), then read 0x10 -> bresp 0, bvalid 1 cycle after handshake; rdata 0xDEADBEEF, rvalid 2 cycles after AR.
REQ-030 AW at addr 0x20 three cycles before W=0x12345678, then W before AW at 0x24 (0x9ABCDEF0) -> readback gives both values; each B arrives only after its pair completes.
REQ-031 Write 0xFFFFFFFF, then 0x00000000 with wstrb=4'b0101 -> with _EN defined, readback 0xFF00FF00; without _EN, 0x00000000.
REQ-032 Write/read at 4*DEPTH (0x1000 for DEPTH=1024) -> bresp=2'b10, rresp=2'b10, rdata=0; word 0 unchanged.
REQ-033 bready/rready held low 5 cycles -> bvalid/rvalid/data stable; no new AW/AR accepted until the handshake.
REQ-034 Read and write to 0x40 on the same edge (old 0x1, new 0x2), and reset asserted while in W_RESP -> read returns 0x1 and a later read returns 0x2; after reset all valids are 0 and readies are 1 the cycle after release.
